// File: rtl/freq_meter_pkg.sv
// Shared types and width helpers for the gated-window frequency counter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    STORE = 2'd2
  } state_e;

  // Timer width for a count of 0..gate_cycles-1; never narrower than one bit.
  function automatic int timer_width(input int gate_cycles);
    return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_counter_avg_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input followed by a registered
// rising-edge detector; rise is a one-cycle pulse per synchronised 0->1 transition.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/freq_counter_avg.sv
// Gated-window frequency counter: counts rising edges of sig_in over GATE_CYCLES
// clocks and keeps a running average of the last 2^AVG_LOG2 window counts.
module freq_counter_avg
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 27,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic [CNT_W-1:0] avg,
  output logic             avg_valid,
  output logic             ovf
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int TW    = timer_width(GATE_CYCLES);
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int SW    = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [TW-1:0]    timer_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] buf_q [DEPTH];
  logic [SW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [FW-1:0]    fill_q;
  logic             busy_q, done_q, avg_valid_q, ovf_q;
  logic [CNT_W-1:0] freq_q, avg_q;
  logic             rise_w;
  logic             timer_last;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sig_in),
    .rise    (rise_w)
  );

  // Saturating edge counter; the flag records that at least one edge was lost.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cnt_d     = cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (rise_w) begin
      if (cnt_q == CNT_MAX) ovf_cnt_d = 1'b1;
      else                  cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  assign timer_last = (timer_q == TW'(GATE_CYCLES - 1));
  assign sum_d      = sum_q + SW'(cnt_d) - SW'(buf_q[wptr_q]);
  assign wptr_d     = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);

  // The store updates land on the edge entering STORE so that freq/avg/done
  // become visible together during the STORE cycle; clr sampled on that edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      ovf_cnt_q   <= 1'b0;
      sum_q       <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      freq_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      // NOTE: the window is reset because the running sum assumes zeroed slots.
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking everywhere so every register sees pre-edge values.
      done_q <= 1'b0;

      if (clr) begin
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        sum_q       <= '0;
        wptr_q      <= '0;
        fill_q      <= '0;
        avg_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start || cont) begin
            state_q   <= GATE;
            timer_q   <= '0;
            cnt_q     <= '0;
            ovf_cnt_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        GATE: begin
          timer_q   <= timer_q + TW'(1);
          cnt_q     <= cnt_d;
          ovf_cnt_q <= ovf_cnt_d;
          if (timer_last) begin
            state_q <= STORE;
            done_q  <= 1'b1;
            freq_q  <= cnt_d;
            ovf_q   <= ovf_cnt_d;
            if (clr) begin
              avg_q <= '0;
            end else begin
              buf_q[wptr_q] <= cnt_d;
              sum_q         <= sum_d;
              wptr_q        <= wptr_d;
              avg_q         <= sum_d[SW-1:AVG_LOG2];
              avg_valid_q   <= (fill_q >= FW'(DEPTH - 1));
              if (fill_q != FW'(DEPTH)) fill_q <= fill_q + FW'(1);
            end
          end
        end

        STORE: begin
          if (cont) begin
            state_q   <= GATE;
            timer_q   <= '0;
            cnt_q     <= '0;
            ovf_cnt_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign freq      = freq_q;
  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/freq_counter_avg.md
# freq_counter_avg

Gated-window frequency counter with a moving-average stage, generalising the board-level frequency meter. An asynchronous input is synchronised and its rising edges are counted over a parameterised gate window. Each window's count is pushed into a 2^AVG_LOG2-deep circular buffer, and the block outputs both the latest count and the running average. It sits between a signal source (pin or on-chip timer) and the bin-to-BCD / seven-segment display path.

## Interface
- GATE_CYCLES, 100_000_000: gate window length in clk cycles (1 s at 100 MHz); must be ≥ 4.
- CNT_W, 27: width of the edge count, freq and avg outputs.
- AVG_LOG2, 2: log2 of averaging depth (depth 4); 0 gives no averaging.
- SYNC_STAGES, 2: flip-flops in the input synchroniser; must be ≥ 2.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  asynchronous signal under measurement.
- start  input  1  single-cycle pulse that begins one measurement when idle.
- cont  input  1  1 = back-to-back gates, sampled at each gate end.
- clr  input  1  synchronous clear of the average buffer, running sum and fill count.
- busy  output  1  high while a gate or store is in progress.
- done  output  1  one-cycle pulse when freq/avg update.
- freq  output  CNT_W  edge count of the last completed gate.
- avg  output  CNT_W  average of the last 2^AVG_LOG2 counts.
- avg_valid  output  1  buffer has filled at least once since reset/clr.
- ovf  output  1  last completed gate saturated its counter.

## Operation
- **Input path.** SYNC_STAGES-flop synchroniser, then a registered rising-edge detector producing `edge`.
- **FSM states: IDLE, GATE, STORE.**
  - IDLE → GATE on `start` or `cont`=1. Timer and edge counter clear on entry.
  - GATE: the timer counts 0..GATE_CYCLES-1. The edge counter increments on `edge`. On the last timer value (including an edge in that cycle) → STORE.
  - STORE (1 cycle):
    - Latch freq, ovf.
    - Write the count to buffer[wptr]; `sum <= sum + count - buffer[wptr]` (old entry).
    - Advance wptr, which wraps at 2^AVG_LOG2.
    - Increment the fill count until full.
    - Pulse done.
    - Next state is GATE if `cont`=1, else IDLE.
- **Edges in STORE/IDLE are not counted.** In continuous mode there is a one-cycle dead time per window.
- **Arithmetic.**
  - The edge counter saturates at 2^CNT_W-1 and sets the internal ovf flag for that gate.
  - `sum` is CNT_W+AVG_LOG2 bits and never overflows.
  - `avg = sum >> AVG_LOG2` (truncating), registered in STORE.
  - The buffer resets to zero, so avg is meaningful only once avg_valid=1. avg_valid rises in the STORE that fills the last slot.
- **start while busy** is ignored.
- **cont dropped mid-gate:** the current gate completes, then the FSM goes to IDLE.
- **clr:**
  - Zeroes the buffer, sum, wptr, fill count and avg_valid.
  - Does not abort a gate or affect freq/ovf.
  - clr in the same cycle as STORE: clr wins for buffer state; freq/ovf still update; done still pulses; avg reads 0.
- **Async reset mid-gate:** everything returns to the reset state, and the FSM goes to IDLE.

## Timing
- Reset values: busy=0, done=0, freq=0, avg=0, avg_valid=0, ovf=0; FSM IDLE; buffer, sum and pointers zero.
- sig_in rising edge to counted: SYNC_STAGES+1 cycles.
- Start to done: `start` high in cycle t, GATE occupies t+1..t+GATE_CYCLES, STORE/done is at t+GATE_CYCLES+1.
- freq, avg, avg_valid and ovf change only in the done cycle and hold until the next one.
- busy is high in GATE and STORE. It drops the cycle after STORE when going to IDLE.
- Continuous mode: done period is exactly GATE_CYCLES+1 cycles.

## Structure
- Package `freq_meter_pkg`: FSM state enum (IDLE, GATE, STORE) and a `clog2`-based width helper for the timer (`$clog2(GATE_CYCLES)`).
- Sub-module `edge_sync`: SYNC_STAGES synchroniser plus rising-edge detector, parameter SYNC_STAGES, ports clk, reset_n, d, rise.
- Buffer: a register array inside the top. No external RAM.

## Test plan
Unless noted, the bench uses GATE_CYCLES=100, CNT_W=8, AVG_LOG2=2.

- **Basic count.** sig_in period 10 clk, start pulse → done at start+101 cycles, freq=10 (±1 for phase), ovf=0, busy falls one cycle after done.
- **Averaging fill.** cont=1 with periods 10, 5, 4, 2 clk in successive gates → freq ≈10, 20, 25, 50. avg_valid rises on the 4th done; avg=(10+20+25+50)>>2=26.
- **Wrap-around.** Continue with period 2 for 4 more gates → avg converges to 50 after the 8th done, and the oldest entries are evicted in order.
- **Saturation.** Use CNT_W=4 with sig_in period 2 → freq=15, ovf=1. The next gate, with period 20, gives freq=5 and ovf=0.
- **Control corners.**
  - start during GATE: no effect.
  - cont dropped mid-gate: exactly one more done, then IDLE.
  - clr coincident with STORE: done pulses, freq updates, avg=0, avg_valid=0.
- **Reset mid-gate.** Assert reset_n=0 for 3 cycles at timer=50 → all outputs 0, IDLE. A fresh start then yields a full 100-cycle gate.
